// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Front-end sequencer for an 8-bit combinational ALU.
//
// It collects a three-byte command (opcode, operand A, operand B) from a
// valid/ready byte stream. It then holds the registered operands and opcode
// on the ALU inputs for a settle window. After that it samples the ALU result
// that matches the opcode and presents it, with its flags, on a valid/ready
// result port.
//
// It also detects illegal opcodes and aborts a command when the gap between
// beats is too long. A wrapping counter records completed operations.
//
// Parameters
//   TIMEOUT   : consecutive idle cycles tolerated between beats while waiting
//               for A or B; 0 disables the abort.
//   EXEC_WAIT : cycles the ALU inputs are held before the result is sampled
//               (1..15).
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : byte stream handshake, in_data = command byte
//   alu_a/alu_b/alu_op  : registered operands and operation to the ALU
//   alu_sum/alu_cout    : ALU add result and carry
//   alu_diff/alu_bout   : ALU subtract result and borrow
//   alu_xor/alu_shl     : ALU xor and left-shift results
//   out_valid/out_ready : result handshake
//   out_result/out_flag : selected result, carry/borrow flag
//   out_zero/out_op     : result-is-zero, opcode of this result
//   err_opcode          : one-cycle pulse, illegal opcode byte consumed
//   err_timeout         : one-cycle pulse, partial command aborted
//   done_count          : completed operations, wraps at 256
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int TIMEOUT   = 16,
    parameter int EXEC_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_sum,
    input  logic       alu_cout,
    input  logic [7:0] alu_diff,
    input  logic       alu_bout,
    input  logic [7:0] alu_xor,
    input  logic [7:0] alu_shl,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_flag,
    output logic       out_zero,
    output logic [1:0] out_op,
    output logic       err_opcode,
    output logic       err_timeout,
    output logic [7:0] done_count
);

    // State encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GET_A = 3'd1;
    localparam logic [2:0] ST_GET_B = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // The timeout counter only needs to reach TIMEOUT-1.
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // The EXEC counter starts at 0 on the cycle after B is accepted. The
    // result is captured on the edge where it equals EXEC_WAIT. Therefore
    // out_valid rises EXEC_WAIT+1 edges after the B edge.
    localparam logic [3:0] EX_LAST = 4'(EXEC_WAIT);

    // Registered state
    logic [2:0]      state_q,       state_d;
    logic [7:0]      alu_a_q,       alu_a_d;
    logic [7:0]      alu_b_q,       alu_b_d;
    logic [1:0]      alu_op_q,      alu_op_d;
    logic [TO_W-1:0] to_cnt_q,      to_cnt_d;
    logic [3:0]      ex_cnt_q,      ex_cnt_d;
    logic            out_valid_q,   out_valid_d;
    logic [7:0]      out_result_q,  out_result_d;
    logic            out_flag_q,    out_flag_d;
    logic            out_zero_q,    out_zero_d;
    logic [1:0]      out_op_q,      out_op_d;
    logic            err_opcode_q,  err_opcode_d;
    logic            err_timeout_q, err_timeout_d;
    logic [7:0]      done_count_q,  done_count_d;

    // Helper signals
    logic       in_xfer;
    logic       out_xfer;
    logic       timeout_hit;
    logic [7:0] sel_result;
    logic       sel_flag;

    // Bytes are accepted only while collecting a command. This stalls the
    // upstream during execution and while a result waits downstream.
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_GET_A) ||
                      (state_q == ST_GET_B);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid_q & out_ready;

    // Abort fires on the last tolerated idle cycle only when no beat is
    // present. A beat arriving on that same cycle takes priority.
    assign timeout_hit = (TIMEOUT != 0) && !in_valid && (to_cnt_q == TO_LAST);

    // Result/flag selection from the ALU lines for the latched opcode
    always_comb begin
        sel_result = alu_diff;
        sel_flag   = alu_bout;
        case (alu_op_q)
            2'b00: begin
                sel_result = alu_diff;
                sel_flag   = alu_bout;
            end
            2'b01: begin
                sel_result = alu_sum;
                sel_flag   = alu_cout;
            end
            2'b10: begin
                sel_result = alu_xor;
                sel_flag   = 1'b0;
            end
            default: begin
                sel_result = alu_shl;
                sel_flag   = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        to_cnt_d      = to_cnt_q;
        ex_cnt_d      = ex_cnt_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_flag_d    = out_flag_q;
        out_zero_d    = out_zero_q;
        out_op_d      = out_op_q;
        err_opcode_d  = 1'b0;
        err_timeout_d = 1'b0;
        done_count_d  = done_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    if (in_data[7:2] != 6'd0) begin
                        // Illegal opcode: the byte is consumed and dropped.
                        // The ALU opcode keeps its previous value.
                        err_opcode_d = 1'b1;
                    end else begin
                        alu_op_d = in_data[1:0];
                        to_cnt_d = '0;
                        state_d  = ST_GET_A;
                    end
                end
            end

            ST_GET_A: begin
                if (in_xfer) begin
                    alu_a_d  = in_data;
                    to_cnt_d = '0;
                    state_d  = ST_GET_B;
                end else if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            ST_GET_B: begin
                if (in_xfer) begin
                    alu_b_d  = in_data;
                    to_cnt_d = '0;
                    ex_cnt_d = '0;
                    state_d  = ST_EXEC;
                end else if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            ST_EXEC: begin
                if (ex_cnt_q == EX_LAST) begin
                    out_result_d = sel_result;
                    out_flag_d   = sel_flag;
                    out_zero_d   = (sel_result == 8'd0);
                    out_op_d     = alu_op_q;
                    out_valid_d  = 1'b1;
                    ex_cnt_d     = '0;
                    state_d      = ST_DONE;
                end else begin
                    ex_cnt_d = ex_cnt_q + 4'd1;
                end
            end

            ST_DONE: begin
                // The result fields are left untouched on transfer. Only
                // out_valid drops.
                if (out_xfer) begin
                    out_valid_d  = 1'b0;
                    done_count_d = done_count_q + 8'd1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= 8'd0;
            alu_b_q       <= 8'd0;
            alu_op_q      <= 2'd0;
            to_cnt_q      <= '0;
            ex_cnt_q      <= 4'd0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 8'd0;
            out_flag_q    <= 1'b0;
            out_zero_q    <= 1'b0;
            out_op_q      <= 2'd0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            done_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            to_cnt_q      <= to_cnt_d;
            ex_cnt_q      <= ex_cnt_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_flag_q    <= out_flag_d;
            out_zero_q    <= out_zero_d;
            out_op_q      <= out_op_d;
            err_opcode_q  <= err_opcode_d;
            err_timeout_q <= err_timeout_d;
            done_count_q  <= done_count_d;
        end
    end

    // Output drive
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_flag    = out_flag_q;
    assign out_zero    = out_zero_q;
    assign out_op      = out_op_q;
    assign err_opcode  = err_opcode_q;
    assign err_timeout = err_timeout_q;
    assign done_count  = done_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed plus randomized bench for alu_cmd_sequencer.
//
// A behavioural ALU stub answers the DUT's operand outputs. Expected results
// are derived from the command bytes with plain integer arithmetic. All
// inputs change, and all outputs are sampled, on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int TIMEOUT   = 4;
    localparam int EXEC_WAIT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_sum, alu_diff, alu_xor, alu_shl;
    logic       alu_cout, alu_bout;
    logic       out_valid, out_ready;
    logic [7:0] out_result;
    logic       out_flag, out_zero;
    logic [1:0] out_op;
    logic       err_opcode, err_timeout;
    logic [7:0] done_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_done = 0;
    logic [1:0] exp_op = 2'd0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.TIMEOUT(TIMEOUT), .EXEC_WAIT(EXEC_WAIT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .alu_diff(alu_diff), .alu_bout(alu_bout),
        .alu_xor(alu_xor), .alu_shl(alu_shl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flag(out_flag), .out_zero(out_zero),
        .out_op(out_op), .err_opcode(err_opcode), .err_timeout(err_timeout),
        .done_count(done_count)
    );

    // Combinational ALU stub
    always_comb begin
        {alu_cout, alu_sum}  = {1'b0, alu_a} + {1'b0, alu_b};
        {alu_bout, alu_diff} = {1'b0, alu_a} - {1'b0, alu_b};
        alu_xor              = alu_a ^ alu_b;
        alu_shl              = alu_a << alu_b[2:0];
    end

    // Expected result from plain integer arithmetic
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output logic [7:0] res, output logic flag);
        int r;
        case (op)
            0:       begin r = a - b;            flag = (a < b);  end
            1:       begin r = a + b;            flag = (r > 255); end
            2:       begin r = a ^ b;            flag = 1'b0;     end
            default: begin r = a * (1 << (b % 8)); flag = 1'b0;   end
        endcase
        res = 8'(r & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte after 'gap' idle cycles; returns on the falling edge
    // following the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst      = 1'b0;
        exp_done = 0;
        exp_op   = 2'd0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int gap_max, input int stall);
        logic [7:0] er;
        logic       ef;
        int         cyc;
        ref_alu(int'(op), int'(a), int'(b), er, ef);
        out_ready = (stall == 0);
        send_byte({6'd0, op}, int'($urandom_range(0, gap_max)));
        chk("alu_op", 32'(alu_op), 32'(op));
        exp_op = op;
        send_byte(a, int'($urandom_range(0, gap_max)));
        chk("alu_a", 32'(alu_a), 32'(a));
        send_byte(b, int'($urandom_range(0, gap_max)));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("in_ready_exec", 32'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, EXEC_WAIT + 1);
        chk("out_result", 32'(out_result), 32'(er));
        chk("out_flag", 32'(out_flag), 32'(ef));
        chk("out_zero", 32'(out_zero), 32'(er == 8'd0));
        chk("out_op", 32'(out_op), 32'(op));
        chk("err_quiet", 32'({err_opcode, err_timeout}), 0);
        $display("cmd op=%0d a=0x%02h b=0x%02h -> result=0x%02h flag=%0d stall=%0d",
                 op, a, b, out_result, out_flag, stall);
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_result", 32'(out_result), 32'(er));
                chk("hold_zero", 32'(out_zero), 32'(er == 8'd0));
                chk("hold_in_ready", 32'(in_ready), 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        exp_done = (exp_done + 1) % 256;
        chk("valid_clear", 32'(out_valid), 0);
        chk("done_count", 32'(done_count), exp_done);
        chk("result_kept", 32'(out_result), 32'(er));
        chk("in_ready_back", 32'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    task automatic run_timeout(input logic [7:0] opb, input logic [7:0] a, input bit send_a);
        send_byte(opb, 0);
        chk("to_op", 32'(alu_op), 32'(opb[1:0]));
        exp_op = opb[1:0];
        if (send_a) send_byte(a, 0);
        chk("to_early", 32'(err_timeout), 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            chk("to_pulse", 32'(err_timeout), 32'(k == TIMEOUT));
        end
        @(negedge clk);
        chk("to_single", 32'(err_timeout), 0);
        chk("to_in_ready", 32'(in_ready), 1);
        $display("timeout op_byte=0x%02h send_a=%0d", opb, send_a);
    endtask

    task automatic run_illegal(input logic [7:0] b);
        send_byte(b, 0);
        chk("err_opcode", 32'(err_opcode), 1);
        chk("op_unchanged", 32'(alu_op), 32'(exp_op));
        chk("illegal_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("err_opcode_single", 32'(err_opcode), 0);
        $display("illegal opcode byte=0x%02h", b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] ra;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b0;

        // Reset values
        do_reset(3);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
        chk("rst_out", 32'({out_result, out_flag, out_zero, out_op}), 0);
        chk("rst_err", 32'({err_opcode, err_timeout}), 0);
        chk("rst_done", 32'(done_count), 0);

        // Reset in the middle of a command
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        do_reset(2);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_alu_a", 32'(alu_a), 0);
        chk("midrst_done", 32'(done_count), 0);
        run_cmd(2'b10, 8'h5A, 8'h0F, 0, 0);

        // Add with carry
        run_cmd(2'b01, 8'hC8, 8'h64, 0, 0);

        // Subtract to zero under backpressure
        run_cmd(2'b00, 8'h37, 8'h37, 0, 5);

        // Timeout in GET_B, then a new opcode
        run_timeout(8'h02, 8'h33, 1'b1);
        run_cmd(2'b11, 8'h81, 8'h03, 0, 0);

        // Illegal opcode, then a normal command
        run_illegal(8'h85);
        run_cmd(2'b01, 8'h10, 8'h20, 0, 1);

        // Randomized mix; gaps up to TIMEOUT-1 must never abort
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            ra = 8'($urandom);
            if (r == 0)
                run_illegal(8'($urandom_range(4, 255)));
            else if (r == 1)
                run_timeout({6'd0, 2'($urandom_range(0, 3))}, ra, 1'($urandom_range(0, 1)));
            else if (r == 2)
                run_cmd(2'b00, ra, ra, TIMEOUT - 1, int'($urandom_range(0, 3)));
            else
                run_cmd(2'($urandom_range(0, 3)), ra, 8'($urandom), TIMEOUT - 1,
                        int'($urandom_range(0, 3)));
        end

        // Reset while a result is pending and being accepted
        out_ready = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        repeat (EXEC_WAIT + 1) @(negedge clk);
        chk("pend_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        do_reset(1);
        out_ready = 1'b0;
        chk("pend_dropped", 32'(out_valid), 0);
        chk("pend_done", 32'(done_count), 0);

        // done_count wraps after 256 completions
        for (int i = 0; i < 256; i++)
            run_cmd(2'b10, 8'($urandom), 8'($urandom), 0, 0);
        chk("wrap_done", 32'(done_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
